// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C init sequencer: table entry layout, op codes, FSM states.
package i2c_pkg;

  localparam int ENTRY_W = 18;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DELAY,
    ST_FINISH
  } st_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [1:0] op,
                                                  input logic [7:0] addr,
                                                  input logic [7:0] data);
    return {op, addr, data};
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Init command table, purely combinational: index in, {op, addr, data} out.
module i2c_init_rom
  import i2c_pkg::*;
(
  input  logic [7:0]         i_idx,
  output logic [ENTRY_W-1:0] o_entry
);

  // Unlisted indices read as END so a short table terminates cleanly.
  always_comb begin
    o_entry = mk_entry(OP_END, 8'h00, 8'h00);
    case (i_idx)
      8'd0:    o_entry = mk_entry(OP_WRITE, 8'h0F, 8'h00);
      8'd1:    o_entry = mk_entry(OP_WRITE, 8'h07, 8'h0A);
      8'd2:    o_entry = mk_entry(OP_DELAY, 8'h00, 8'h03);
      8'd3:    o_entry = mk_entry(OP_WRITE, 8'h09, 8'h01);
      8'd4:    o_entry = mk_entry(OP_END,   8'h00, 8'h00);
      default: ;
    endcase
  end

endmodule

// File: rtl/i2c_init_seq.sv
// Walks the init table, issuing I2C writes and delays (delay counting needs I2C_INIT_DELAY_EN).
// Latency: 2 cycles from entry fetch to i2c_valid; DELAY costs data*WAIT_CLKS clocks, or 1 when disabled.
// Backpressure: i2c_valid and fields hold until i2c_ready; FINISH waits for i2c_ready before done.
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int unsigned N_CMDS    = 16,
  parameter logic [7:0]  DEVICE    = 8'h34,
  parameter int unsigned WAIT_CLKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       i2c_valid,
  input  logic       i2c_ready,
  output logic [7:0] i2c_device,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data
);

  if (N_CMDS < 1 || N_CMDS > 256 || WAIT_CLKS < 1) begin : g_bad_cfg
    $error("i2c_init_seq: parameter out of range");
  end

  localparam logic [8:0] LAST_IDX = 9'(N_CMDS);

  st_t                r_state;
  logic [8:0]         r_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic [7:0]         r_dev;
  logic [7:0]         r_addr;
  logic [7:0]         r_data;
  logic [ENTRY_W-1:0] w_entry;
  logic [1:0]         w_op;

  i2c_init_rom u_rom (
    .i_idx   (r_idx[7:0]),
    .o_entry (w_entry)
  );

  assign w_op = w_entry[17:16];

`ifdef I2C_INIT_DELAY_EN
  logic [31:0] r_cnt;
  logic [31:0] w_dly_clks;
  assign w_dly_clks = 32'(w_entry[7:0]) * 32'(WAIT_CLKS);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_dev   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef I2C_INIT_DELAY_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Running off the end of the table behaves like an END entry.
          if (r_idx == LAST_IDX) begin
            r_state <= ST_FINISH;
          end else begin
            case (w_op)
              OP_WRITE: begin
                r_dev   <= DEVICE;
                r_addr  <= w_entry[15:8];
                r_data  <= w_entry[7:0];
                r_valid <= 1'b1;
                r_state <= ST_ISSUE;
              end
              OP_DELAY: begin
`ifdef I2C_INIT_DELAY_EN
                if (w_dly_clks == '0) begin
                  r_idx <= r_idx + 9'd1;
                end else begin
                  r_cnt   <= w_dly_clks;
                  r_state <= ST_DELAY;
                end
`else
                r_idx <= r_idx + 9'd1;
`endif
              end
              default: r_state <= ST_FINISH;
            endcase
          end
        end
        ST_ISSUE: begin
          if (r_valid && i2c_ready) begin
            r_valid <= 1'b0;
            r_idx   <= r_idx + 9'd1;
            r_state <= ST_FETCH;
          end
        end
`ifdef I2C_INIT_DELAY_EN
        ST_DELAY: begin
          r_cnt <= r_cnt - 32'd1;
          if (r_cnt == 32'd1) begin
            r_idx   <= r_idx + 9'd1;
            r_state <= ST_FETCH;
          end
        end
`endif
        ST_FINISH: begin
          if (i2c_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign i2c_valid  = r_valid;
  assign i2c_device = r_dev;
  assign i2c_addr   = r_addr;
  assign i2c_data   = r_data;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: two instances (full table with WAIT_CLKS=10, and N_CMDS=2).
module tb_i2c_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, i2c_ready;
  logic       busy, done, i2c_valid;
  logic [7:0] i2c_device, i2c_addr, i2c_data;

  logic       start2, ready2;
  logic       busy2, done2, valid2;
  logic [7:0] dev2, addr2, data2;

  i2c_init_seq #(.N_CMDS(16), .DEVICE(8'h34), .WAIT_CLKS(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i2c_valid(i2c_valid), .i2c_ready(i2c_ready),
    .i2c_device(i2c_device), .i2c_addr(i2c_addr), .i2c_data(i2c_data)
  );

  i2c_init_seq #(.N_CMDS(2), .DEVICE(8'h34), .WAIT_CLKS(10)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .i2c_valid(valid2), .i2c_ready(ready2),
    .i2c_device(dev2), .i2c_addr(addr2), .i2c_data(data2)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Negedge monitor: handshakes, valid rises, hold stability, busy/done exclusivity.
  int          cyc = 0;
  logic [23:0] hs_q[$];
  int          hs_cyc[$];
  int          rise_cyc[$];
  logic        prev_v = 1'b0, prev_hs = 1'b0, prev_rst = 1'b0;
  logic [23:0] prev_f = '0;
  int          stab_err = 0, both_err = 0;
  int          hs2_n = 0;
  logic [23:0] hs2_last = '0;

  always @(negedge clk) begin
    cyc++;
    if (i2c_valid && i2c_ready) begin
      hs_q.push_back({i2c_device, i2c_addr, i2c_data});
      hs_cyc.push_back(cyc);
    end
    if (i2c_valid && !prev_v) rise_cyc.push_back(cyc);
    if (prev_v && !prev_hs && !prev_rst)
      if (!i2c_valid || {i2c_device, i2c_addr, i2c_data} != prev_f) stab_err++;
    if ((busy && done) || (busy2 && done2)) both_err++;
    if (valid2 && ready2) begin
      hs2_n++;
      hs2_last = {dev2, addr2, data2};
    end
    prev_v   = i2c_valid;
    prev_hs  = i2c_valid && i2c_ready;
    prev_rst = rst;
    prev_f   = {i2c_device, i2c_addr, i2c_data};
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done && k < max) begin
      tick();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!i2c_valid && k < max) begin
      tick();
      k++;
    end
    check(tag, 32'(i2c_valid), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int gap;

  initial begin
    rst = 1'b1; start = 1'b0; i2c_ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(i2c_valid), 32'd0);
    check("rst_fields", {8'h0, i2c_device, i2c_addr, i2c_data}, 32'h0);
    rst = 1'b0;
    tick(5);
    check("no_autostart", {30'h0, busy, i2c_valid}, 32'h0);

    // Full run with ready tied high; second DUT runs its 2-entry table alongside.
    i2c_ready = 1'b1; ready2 = 1'b1;
    start = 1'b1; start2 = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    check("start_busy", {30'h0, busy, done}, 32'h2);
    tick(2);
    pulse_start();
    wait_done("run1_done", 200);
    check("run1_busy", 32'(busy), 32'd0);
    check("run1_n_hs", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() == 3) begin
      check("run1_hs0", 32'(hs_q[0]), 32'h340F00);
      check("run1_hs1", 32'(hs_q[1]), 32'h34070A);
      check("run1_hs2", 32'(hs_q[2]), 32'h340901);
    end
    if (hs_cyc.size() >= 2 && rise_cyc.size() >= 3) begin
      gap = rise_cyc[2] - hs_cyc[1] - 1;
`ifdef I2C_INIT_DELAY_EN
      check("delay_gap_28_32", 32'(gap >= 28 && gap <= 32), 32'd1);
`else
      check("delay_gap_le2", 32'(gap <= 2), 32'd1);
`endif
    end
    check("ncmd2_done", 32'(done2), 32'd1);
    check("ncmd2_n_hs", 32'(hs2_n), 32'd2);
    check("ncmd2_last", 32'(hs2_last), 32'h34070A);
    tick(10);
    check("done_sticky", 32'(done), 32'd1);
    check("ncmd2_no_third", 32'(hs2_n), 32'd2);

    // Backpressure: hold ready low for 50 cycles while valid is up.
    hs_q.delete();
    i2c_ready = 1'b0;
    pulse_start();
    check("restart_clears_done", 32'(done), 32'd0);
    wait_valid("bp_valid", 20);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_hold", {7'h0, i2c_valid, i2c_device, i2c_addr, i2c_data}, 32'h01340F00);
    end
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    tick(5);
    check("bp_one_xfer", 32'(hs_q.size()), 32'd1);
    check("bp_next_pending", {7'h0, i2c_valid, i2c_device, i2c_addr, i2c_data}, 32'h0134070A);
    i2c_ready = 1'b1;
    wait_done("bp_done", 200);
    check("bp_n_hs", 32'(hs_q.size()), 32'd3);

    // Reset while a write is pending.
    i2c_ready = 1'b0;
    pulse_start();
    wait_valid("abort_valid", 20);
    rst = 1'b1;
    tick();
    check("abort_state", {29'h0, i2c_valid, busy, done}, 32'h0);
    rst = 1'b0;
    start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    tick();
    check("rst_beats_start", 32'(busy), 32'd0);

    // Replay from entry 0 after the abort.
    hs_q.delete();
    i2c_ready = 1'b1;
    pulse_start();
    wait_done("replay_done", 200);
    check("replay_n_hs", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() > 0) check("replay_hs0", 32'(hs_q[0]), 32'h340F00);

    check("hold_stable", 32'(stab_err), 32'd0);
    check("busy_done_excl", 32'(both_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
